// File: rtl/nexys_starship_room_repair.sv
// Per-room repair controller: tracks hit/broken/repair state for one starship room.
// Latency: all outputs registered; pulses appear one cycle after the causing input.
// Optional macro ROOM_REPAIR_SCORE_EN enables the saturating repair_count score counter.
module nexys_starship_room_repair #(
  parameter int unsigned  TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned  MAX_WRONG      = 3,
  parameter logic [7:0]   LFSR_SEED      = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       game_over,
  input  logic       hit,
  input  logic       combo_valid,
  input  logic [3:0] combo_in,
  output logic       q_Init,
  output logic       q_Working,
  output logic       q_Repair,
  output logic       broken,
  output logic [3:0] repair_combo,
  output logic [3:0] wrong_cnt,
  output logic       repair_done,
  output logic       room_lost,
  output logic [7:0] repair_count
);

  // One-hot encoding so the state outputs come straight from flop bits.
  typedef enum logic [2:0] {
    ST_INIT    = 3'b001,
    ST_WORKING = 3'b010,
    ST_REPAIR  = 3'b100
  } state_e;

  localparam logic [28:0] TIMER_LAST  = 29'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]  MAX_WRONG_W = 5'(MAX_WRONG);

  state_e      state_q;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [28:0] timer_q;
  logic [3:0]  repair_combo_q;
  logic [3:0]  wrong_cnt_q;
  logic        broken_q;
  logic        repair_done_q;
  logic        room_lost_q;

  logic [3:0]  new_combo;
  logic [4:0]  wrong_inc;
  logic        combo_match;
  logic        timer_expired;
  logic        repair_win;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1; a nonzero seed keeps it off the all-zero lockup state.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // A zero combo would match the switches' idle value, so substitute 1.
  assign new_combo     = (lfsr_q[3:0] == 4'h0) ? 4'h1 : lfsr_q[3:0];
  assign wrong_inc     = {1'b0, wrong_cnt_q} + 5'd1;
  assign combo_match   = (combo_in == repair_combo_q);
  assign timer_expired = (timer_q == TIMER_LAST);
  assign repair_win    = (state_q == ST_REPAIR) && !game_over && combo_valid && combo_match;

  // Free-running combo generator.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  // Room FSM with registered outputs; combo evaluation outranks the repair timeout.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q        <= ST_INIT;
      timer_q        <= '0;
      repair_combo_q <= '0;
      wrong_cnt_q    <= '0;
      broken_q       <= 1'b0;
      repair_done_q  <= 1'b0;
      room_lost_q    <= 1'b0;
    end else begin
      repair_done_q <= 1'b0;
      room_lost_q   <= 1'b0;
      case (state_q)
        ST_INIT: begin
          if (play_flag) state_q <= ST_WORKING;
        end
        ST_WORKING: begin
          if (game_over) begin
            state_q <= ST_INIT;
          end else if (hit) begin
            state_q        <= ST_REPAIR;
            repair_combo_q <= new_combo;
            timer_q        <= '0;
            wrong_cnt_q    <= '0;
            broken_q       <= 1'b1;
          end
        end
        ST_REPAIR: begin
          if (game_over) begin
            state_q     <= ST_INIT;
            broken_q    <= 1'b0;
            wrong_cnt_q <= '0;
            timer_q     <= '0;
          end else if (combo_valid && combo_match) begin
            state_q       <= ST_WORKING;
            broken_q      <= 1'b0;
            repair_done_q <= 1'b1;
            wrong_cnt_q   <= '0;
          end else if (combo_valid) begin
            if (wrong_inc < MAX_WRONG_W) begin
              wrong_cnt_q <= wrong_inc[3:0];
              timer_q     <= timer_q + 29'd1;
            end else begin
              // Too many wrong guesses: room lost, fresh window with a new combo.
              room_lost_q    <= 1'b1;
              repair_combo_q <= new_combo;
              timer_q        <= '0;
              wrong_cnt_q    <= '0;
            end
          end else if (timer_expired) begin
            room_lost_q    <= 1'b1;
            repair_combo_q <= new_combo;
            timer_q        <= '0;
            wrong_cnt_q    <= '0;
          end else begin
            timer_q <= timer_q + 29'd1;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

`ifdef ROOM_REPAIR_SCORE_EN
  logic [7:0] repair_count_q;

  // Saturating score of successful repairs; only reset clears it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                                   repair_count_q <= '0;
    else if (repair_win && repair_count_q != 8'hFF) repair_count_q <= repair_count_q + 8'd1;
  end

  assign repair_count = repair_count_q;
`else
  assign repair_count = 8'h00;
`endif

  assign q_Init       = state_q[0];
  assign q_Working    = state_q[1];
  assign q_Repair     = state_q[2];
  assign broken       = broken_q;
  assign repair_combo = repair_combo_q;
  assign wrong_cnt    = wrong_cnt_q;
  assign repair_done  = repair_done_q;
  assign room_lost    = room_lost_q;

endmodule

// File: tb/tb_nexys_starship_room_repair.sv
// Directed table-driven bench for nexys_starship_room_repair (short timeout, MAX_WRONG=3).
// Expected combos come from an independent LFSR model snapshotted before each edge.
module tb_nexys_starship_room_repair;

  localparam logic [2:0] S_I = 3'b001;
  localparam logic [2:0] S_W = 3'b010;
  localparam logic [2:0] S_R = 3'b100;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       play_flag = 1'b0, game_over = 1'b0, hit = 1'b0, combo_valid = 1'b0;
  logic [3:0] combo_in = 4'h0;
  logic       q_Init, q_Working, q_Repair, broken, repair_done, room_lost;
  logic [3:0] repair_combo, wrong_cnt;
  logic [7:0] repair_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_lfsr;
  logic [3:0] exp_combo = 4'h0;
  logic [7:0] exp_rc = 8'h00;

  typedef struct {
    logic       pf, go, ht, cv;
    logic [3:0] cx;      // xor applied to the expected combo to form combo_in
    logic       reroll;  // expect a freshly generated combo after this edge
    logic [2:0] st;      // {q_Repair,q_Working,q_Init}
    logic       brk;
    logic [3:0] wc;
    logic       dn, lost;
  } vec_t;

  vec_t tbl[15];

  nexys_starship_room_repair #(
    .TIMEOUT_CYCLES(16),
    .MAX_WRONG(3),
    .LFSR_SEED(8'hA5)
  ) dut (
    .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .game_over(game_over),
    .hit(hit), .combo_valid(combo_valid), .combo_in(combo_in),
    .q_Init(q_Init), .q_Working(q_Working), .q_Repair(q_Repair),
    .broken(broken), .repair_combo(repair_combo), .wrong_cnt(wrong_cnt),
    .repair_done(repair_done), .room_lost(room_lost), .repair_count(repair_count)
  );

  always #5 Clk = ~Clk;

  // Reference LFSR for x^8+x^6+x^5+x^4+1 seeded with A5.
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " state"}, {29'd0, q_Repair, q_Working, q_Init}, {29'd0, S_I});
    chk({tag, " broken"}, {31'd0, broken}, 32'd0);
    chk({tag, " combo"}, {28'd0, repair_combo}, 32'd0);
    chk({tag, " wrong_cnt"}, {28'd0, wrong_cnt}, 32'd0);
    chk({tag, " done"}, {31'd0, repair_done}, 32'd0);
    chk({tag, " lost"}, {31'd0, room_lost}, 32'd0);
    chk({tag, " count"}, {24'd0, repair_count}, 32'd0);
  endtask

  // Drive one vector at the falling edge, then check outputs just after the rising edge.
  task automatic apply(input vec_t v, input string tag);
    logic [7:0] snap;
    @(negedge Clk);
    play_flag   = v.pf;
    game_over   = v.go;
    hit         = v.ht;
    combo_valid = v.cv;
    combo_in    = exp_combo ^ v.cx;
    snap        = m_lfsr;
    @(posedge Clk);
    #1;
    if (v.reroll) exp_combo = (snap[3:0] == 4'h0) ? 4'h1 : snap[3:0];
`ifdef ROOM_REPAIR_SCORE_EN
    if (v.dn && exp_rc != 8'hFF) exp_rc = exp_rc + 8'd1;
`endif
    chk({tag, " state"}, {29'd0, q_Repair, q_Working, q_Init}, {29'd0, v.st});
    chk({tag, " broken"}, {31'd0, broken}, {31'd0, v.brk});
    chk({tag, " wrong_cnt"}, {28'd0, wrong_cnt}, {28'd0, v.wc});
    chk({tag, " done"}, {31'd0, repair_done}, {31'd0, v.dn});
    chk({tag, " lost"}, {31'd0, room_lost}, {31'd0, v.lost});
    chk({tag, " count"}, {24'd0, repair_count}, {24'd0, exp_rc});
    if (v.brk) begin
      chk({tag, " combo"}, {28'd0, repair_combo}, {28'd0, exp_combo});
      chk({tag, " combo_nz"}, {31'd0, (repair_combo != 4'h0)}, 32'd1);
    end
  endtask

  function automatic vec_t mk(input logic pf, go, ht, cv, input logic [3:0] cx,
                              input logic rr, input logic [2:0] st, input logic brk,
                              input logic [3:0] wc, input logic dn, lost);
    vec_t v;
    v.pf = pf; v.go = go; v.ht = ht; v.cv = cv; v.cx = cx; v.reroll = rr;
    v.st = st; v.brk = brk; v.wc = wc; v.dn = dn; v.lost = lost;
    return v;
  endfunction

  initial begin
    //           pf go ht cv  cx    rr  st  brk wc    dn lost
    tbl[0]  = mk(0, 0, 0, 0, 4'h0, 0, S_I, 0, 4'd0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 4'h0, 0, S_W, 0, 4'd0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 1, 4'h0, 0, S_W, 0, 4'd0, 0, 0);
    tbl[3]  = mk(0, 0, 1, 0, 4'h0, 1, S_R, 1, 4'd0, 0, 0);
    tbl[4]  = mk(0, 0, 1, 0, 4'h0, 0, S_R, 1, 4'd0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 1, 4'hF, 0, S_R, 1, 4'd1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 1, 4'hF, 0, S_R, 1, 4'd2, 0, 0);
    tbl[7]  = mk(0, 0, 0, 1, 4'hF, 1, S_R, 1, 4'd0, 0, 1);
    tbl[8]  = mk(0, 0, 0, 1, 4'h0, 0, S_W, 0, 4'd0, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 4'h0, 0, S_W, 0, 4'd0, 0, 0);
    tbl[10] = mk(0, 1, 1, 0, 4'h0, 0, S_I, 0, 4'd0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 4'h0, 0, S_W, 0, 4'd0, 0, 0);
    tbl[12] = mk(0, 0, 1, 0, 4'h0, 1, S_R, 1, 4'd0, 0, 0);
    tbl[13] = mk(0, 0, 0, 1, 4'h5, 0, S_R, 1, 4'd1, 0, 0);
    tbl[14] = mk(0, 1, 0, 1, 4'h0, 0, S_I, 0, 4'd0, 0, 0);

    // Power-on reset.
    repeat (3) @(posedge Clk);
    #1;
    check_reset_vals("por");
    @(negedge Clk);
    Reset = 1'b1;

    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Timeout: room_lost every 16 cycles after REPAIR entry; correct combo on timeout edge wins.
    apply(mk(1, 0, 0, 0, 4'h0, 0, S_W, 0, 4'd0, 0, 0), "to_play");
    apply(mk(0, 0, 1, 0, 4'h0, 1, S_R, 1, 4'd0, 0, 0), "to_hit");
    for (int k = 1; k < 48; k++) begin
      logic lt;
      lt = (k % 16 == 0);
      apply(mk(0, 0, 0, 0, 4'h0, lt, S_R, 1, 4'd0, 0, lt), $sformatf("to_k%0d", k));
    end
    apply(mk(0, 0, 0, 1, 4'h0, 0, S_W, 0, 4'd0, 1, 0), "to_fix_on_timeout");

    // Mid-REPAIR async reset, then deterministic restart from the seed.
    apply(mk(0, 0, 1, 0, 4'h0, 1, S_R, 1, 4'd0, 0, 0), "rst_hit");
    for (int k = 0; k < 5; k++) apply(mk(0, 0, 0, 0, 4'h0, 0, S_R, 1, 4'd0, 0, 0), "rst_run");
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    exp_rc = 8'h00;
    check_reset_vals("midrst");
    @(negedge Clk);
    Reset = 1'b1;
    apply(mk(0, 0, 0, 0, 4'h0, 0, S_I, 0, 4'd0, 0, 0), "post_rst_idle");
    apply(mk(1, 0, 0, 0, 4'h0, 0, S_W, 0, 4'd0, 0, 0), "post_rst_play");
    apply(mk(0, 0, 1, 0, 4'h0, 1, S_R, 1, 4'd0, 0, 0), "post_rst_hit");
    apply(mk(0, 0, 0, 1, 4'h0, 0, S_W, 0, 4'd0, 1, 0), "post_rst_fix");

`ifdef ROOM_REPAIR_SCORE_EN
    // Saturation: 256 more repairs, count must stick at FF and survive game_over.
    for (int i = 0; i < 256; i++) begin
      apply(mk(0, 0, 1, 0, 4'h0, 1, S_R, 1, 4'd0, 0, 0), "sat_hit");
      apply(mk(0, 0, 0, 1, 4'h0, 0, S_W, 0, 4'd0, 1, 0), "sat_fix");
    end
    apply(mk(0, 1, 0, 0, 4'h0, 0, S_I, 0, 4'd0, 0, 0), "sat_gameover");
    chk("sat_final", {24'd0, repair_count}, 32'h0000_00FF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
